// File: rtl/power_rail_sequencer.sv
// Orders regulator enables from a rail-request word: ascending power-up, descending power-down,
// with power-good timeout and dropout detection latched into a fault until requests are withdrawn.
module power_rail_sequencer #(
   parameter int NUM_RAILS     = 5,
   parameter int STEP_DELAY    = 1000,
   parameter int PGOOD_TIMEOUT = 100000,
   parameter int OFF_DELAY     = 1000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_RAILS-1:0] rail_req,
   input  logic [NUM_RAILS-1:0] pgood_in,
   output logic [NUM_RAILS-1:0] rail_en,
   output logic [NUM_RAILS-1:0] rail_good,
   output logic                 busy,
   output logic                 fault,
   output logic [2:0]           fault_rail,
   output logic [1:0]           fault_code
);

   localparam logic [31:0] TMO_LAST    = 32'(PGOOD_TIMEOUT - 1);
   localparam logic [31:0] SETTLE_LAST = 32'(STEP_DELAY - 1);
   localparam logic [31:0] OFF_LAST    = 32'(OFF_DELAY - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RAMP,
      ST_SETTLE,
      ST_OFF_WAIT,
      ST_FAULT
   } state_t;

   state_t               state, state_n;
   logic [31:0]          timer, timer_n;
   logic [2:0]           cur, cur_n;
   logic [NUM_RAILS-1:0] good_mask, good_mask_n, rail_en_n;
   logic [NUM_RAILS-1:0] pg_m, pg_s;
   logic [NUM_RAILS-1:0] down_vec, up_vec, drop_vec;
   logic [2:0]           down_idx, up_idx, drop_idx;
   logic                 fault_n, busy_n;
   logic [2:0]           fault_rail_n;
   logic [1:0]           fault_code_n;

   assign down_vec  = rail_en & ~rail_req;
   assign up_vec    = rail_req & ~rail_en;
   assign drop_vec  = good_mask & ~pg_s;
   assign rail_good = good_mask;

   // Highest rail to drop, lowest rail to raise, lowest rail that lost power-good.
   always_comb begin
      down_idx = '0;
      up_idx   = '0;
      drop_idx = '0;
      for (int i = 0; i < NUM_RAILS; i++) begin
         if (down_vec[i]) down_idx = 3'(i);
      end
      for (int i = NUM_RAILS - 1; i >= 0; i--) begin
         if (up_vec[i]) up_idx = 3'(i);
         if (drop_vec[i]) drop_idx = 3'(i);
      end
   end

   always_comb begin
      state_n      = state;
      cur_n        = cur;
      rail_en_n    = rail_en;
      good_mask_n  = good_mask;
      fault_n      = fault;
      fault_rail_n = fault_rail;
      fault_code_n = fault_code;
      timer_n      = '0;
      busy_n       = 1'b0;

      if (state != ST_FAULT && |drop_vec) begin
         state_n      = ST_FAULT;
         rail_en_n    = '0;
         good_mask_n  = '0;
         fault_n      = 1'b1;
         fault_code_n = 2'd2;
         fault_rail_n = drop_idx;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|down_vec) begin
                  rail_en_n[down_idx]   = 1'b0;
                  good_mask_n[down_idx] = 1'b0;
                  state_n               = ST_OFF_WAIT;
               end else if (|up_vec) begin
                  rail_en_n[up_idx] = 1'b1;
                  cur_n             = up_idx;
                  state_n           = ST_RAMP;
               end
            end
            ST_RAMP: begin
               // A power-good arriving on the last allowed cycle still counts.
               if (pg_s[cur]) begin
                  good_mask_n[cur] = 1'b1;
                  state_n          = ST_SETTLE;
               end else if (timer == TMO_LAST) begin
                  state_n      = ST_FAULT;
                  rail_en_n    = '0;
                  good_mask_n  = '0;
                  fault_n      = 1'b1;
                  fault_code_n = 2'd1;
                  fault_rail_n = cur;
               end
            end
            ST_SETTLE: begin
               if (timer == SETTLE_LAST) state_n = ST_IDLE;
            end
            ST_OFF_WAIT: begin
               if (timer == OFF_LAST) state_n = ST_IDLE;
            end
            ST_FAULT: begin
               if (rail_req == '0) begin
                  state_n      = ST_IDLE;
                  fault_n      = 1'b0;
                  fault_code_n = 2'd0;
                  fault_rail_n = 3'd0;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end

      busy_n = (state_n == ST_RAMP) || (state_n == ST_SETTLE) || (state_n == ST_OFF_WAIT);
      if (state_n == state && busy_n) timer_n = timer + 32'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         timer      <= '0;
         cur        <= '0;
         rail_en    <= '0;
         good_mask  <= '0;
         fault      <= 1'b0;
         fault_rail <= '0;
         fault_code <= '0;
         busy       <= 1'b0;
         pg_m       <= '0;
         pg_s       <= '0;
      end else begin
         state      <= state_n;
         timer      <= timer_n;
         cur        <= cur_n;
         rail_en    <= rail_en_n;
         good_mask  <= good_mask_n;
         fault      <= fault_n;
         fault_rail <= fault_rail_n;
         fault_code <= fault_code_n;
         busy       <= busy_n;
         pg_m       <= pgood_in;
         pg_s       <= pg_m;
      end
   end

endmodule

// File: tb/tb_power_rail_sequencer.sv
// Bench for power_rail_sequencer: an ordering model predicts every change of the rail/fault outputs
// and its timing; a negedge monitor compares observed changes and requested snapshots.
module tb_power_rail_sequencer;

   localparam int NR     = 5;
   localparam int STEP   = 4;
   localparam int TMO    = 20;
   localparam int OFFD   = 3;
   localparam int PG_DLY = 5;
   localparam int EW     = 24;
   localparam logic [7:0] ANY = 8'hFF;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [NR-1:0] rail_req = '0;
   logic [NR-1:0] pg_raw = '0;
   logic [NR-1:0] pg_hold = '0;
   logic [NR-1:0] pgood_in;
   logic [NR-1:0] rail_en, rail_good;
   logic          busy, fault;
   logic [2:0]    fault_rail;
   logic [1:0]    fault_code;

   assign pgood_in = pg_raw & ~pg_hold;

   power_rail_sequencer #(
      .NUM_RAILS    (NR),
      .STEP_DELAY   (STEP),
      .PGOOD_TIMEOUT(TMO),
      .OFF_DELAY    (OFFD)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rail_req  (rail_req),
      .pgood_in  (pgood_in),
      .rail_en   (rail_en),
      .rail_good (rail_good),
      .busy      (busy),
      .fault     (fault),
      .fault_rail(fault_rail),
      .fault_code(fault_code)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Regulator model: power-good rises PG_DLY cycles after its enable, unless held low.
   int pg_cnt [NR];
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NR; i++) begin
         pg_raw[i] = rail_en[i] && (pg_cnt[i] >= PG_DLY);
         if (rail_en[i]) begin
            if (pg_cnt[i] < 1000) pg_cnt[i]++;
         end else begin
            pg_cnt[i] = 0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   // exp_q entry: {cycles since previous event or stimulus (ANY = unchecked), fault, code, rail, good, en}
   logic [EW-1:0] exp_q[$];
   // snap_q entry: {timeout flag, id, busy, fault, code, rail, good, en}
   logic [25:0]   snap_q[$];
   int            checks = 0;
   int            errors = 0;
   int            stim_cyc = 0;
   int            last_evt_cyc = 0;
   logic [15:0]   prev_t = '0;
   logic [7:0]    snap_id = '0;

   always @(negedge clk) begin : monitor
      logic [15:0]   cur_t;
      logic [EW-1:0] e;
      logic [25:0]   s;
      logic [16:0]   act;
      int            base, dt;
      cur_t = {fault, fault_code, fault_rail, rail_good, rail_en};
      if (cur_t !== prev_t) begin
         checks++;
         base = (stim_cyc > last_evt_cyc) ? stim_cyc : last_evt_cyc;
         dt   = cyc - base;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %h at cycle %0d, nothing expected", cur_t, cyc);
         end else begin
            e = exp_q.pop_front();
            if (cur_t !== e[15:0] || (e[23:16] != ANY && dt != int'(e[23:16]))) begin
               errors++;
               $display("FAIL event: got %h after %0d cycles, expected %h after %0d cycles",
                        cur_t, dt, e[15:0], e[23:16]);
            end
         end
         last_evt_cyc = cyc;
         prev_t       = cur_t;
      end
      while (snap_q.size() > 0) begin
         s = snap_q.pop_front();
         checks++;
         if (s[25]) begin
            errors++;
            $display("FAIL timeout#%0d: bounded wait expired, required completion", s[24:17]);
         end else begin
            act = {busy, fault, fault_code, fault_rail, rail_good, rail_en};
            if (act !== s[16:0]) begin
               errors++;
               $display("FAIL snap#%0d: got %h expected %h", s[24:17], act, s[16:0]);
            end
         end
      end
   end

   // ---------------- reference model / driver tasks ----------------
   function automatic logic [15:0] tup(input logic f, input logic [1:0] c, input logic [2:0] r,
                                       input logic [4:0] g, input logic [4:0] e);
      return {f, c, r, g, e};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push_ev(input logic [7:0] d, input logic [15:0] t);
      exp_q.push_back({d, t});
   endtask

   task automatic snap(input logic b, input logic f, input logic [1:0] c, input logic [2:0] r,
                       input logic [4:0] g, input logic [4:0] e);
      snap_q.push_back({1'b0, snap_id, b, f, c, r, g, e});
      snap_id++;
   endtask

   task automatic fail_wait();
      snap_q.push_back({1'b1, snap_id, 17'd0});
      snap_id++;
   endtask

   task automatic drive_req(input logic [4:0] r);
      rail_req = r;
      stim_cyc = cyc;
   endtask

   // Moving from a settled set of rails to a new request: drop extras highest-first, then raise
   // missing rails lowest-first; each rail reports good after PG_DLY plus sync and register delay.
   task automatic push_seq(input logic [4:0] from, input logic [4:0] to);
      logic [4:0] en;
      int d;
      en = from;
      d  = 1;
      for (int i = NR - 1; i >= 0; i--) begin
         if (from[i] && !to[i]) begin
            en[i] = 1'b0;
            push_ev(8'(d), tup(1'b0, 2'd0, 3'd0, en, en));
            d = OFFD + 1;
         end
      end
      for (int i = 0; i < NR; i++) begin
         if (to[i] && !from[i]) begin
            push_ev(8'(d), tup(1'b0, 2'd0, 3'd0, en, en | (5'd1 << i)));
            en[i] = 1'b1;
            push_ev(8'(PG_DLY + 3), tup(1'b0, 2'd0, 3'd0, en, en));
            d = STEP + 1;
         end
      end
   endtask

   task automatic wait_quiet(input int limit);
      int quiet;
      int n;
      quiet = 0;
      n = 0;
      while (quiet < 3 && n < limit) begin
         tick(1);
         n++;
         if (exp_q.size() == 0 && busy == 1'b0) quiet++;
         else quiet = 0;
      end
      if (quiet < 3) begin
         fail_wait();
         exp_q.delete();
      end
   endtask

   function automatic logic [2:0] lowest(input logic [4:0] m);
      logic [2:0] r;
      r = '0;
      for (int i = NR - 1; i >= 0; i--) if (m[i]) r = 3'(i);
      return r;
   endfunction

   // ---------------- stimulus ----------------
   initial begin : stim
      logic [4:0] on;
      logic [4:0] nr;
      logic [4:0] mask;
      int n;

      tick(2);
      snap(1'b0, 1'b0, 2'd0, 3'd0, 5'h00, 5'h00);
      tick(1);
      reset_n = 1'b1;
      tick(2);

      // power-up in ascending order, then power-down in descending order
      push_seq(5'h00, 5'h1F);
      drive_req(5'h1F);
      wait_quiet(1000);
      snap(1'b0, 1'b0, 2'd0, 3'd0, 5'h1F, 5'h1F);
      push_seq(5'h1F, 5'h00);
      drive_req(5'h00);
      wait_quiet(1000);
      snap(1'b0, 1'b0, 2'd0, 3'd0, 5'h00, 5'h00);

      // rail 1 never reports good: timeout fault
      pg_hold = 5'b00010;
      push_ev(8'd1, tup(1'b0, 2'd0, 3'd0, 5'h00, 5'h01));
      push_ev(8'(PG_DLY + 3), tup(1'b0, 2'd0, 3'd0, 5'h01, 5'h01));
      push_ev(8'(STEP + 1), tup(1'b0, 2'd0, 3'd0, 5'h01, 5'h03));
      push_ev(8'(TMO), tup(1'b1, 2'd1, 3'd1, 5'h00, 5'h00));
      drive_req(5'h03);
      wait_quiet(1000);
      snap(1'b0, 1'b1, 2'd1, 3'd1, 5'h00, 5'h00);
      push_ev(8'd1, 16'h0000);
      drive_req(5'h00);
      wait_quiet(1000);
      pg_hold = '0;
      snap(1'b0, 1'b0, 2'd0, 3'd0, 5'h00, 5'h00);

      // dropout of rails 2 and 3 together; fault holds while requests remain
      push_seq(5'h00, 5'h1F);
      drive_req(5'h1F);
      wait_quiet(1000);
      push_ev(8'd3, tup(1'b1, 2'd2, 3'd2, 5'h00, 5'h00));
      pg_hold  = 5'b01100;
      stim_cyc = cyc;
      wait_quiet(1000);
      tick(10);
      snap(1'b0, 1'b1, 2'd2, 3'd2, 5'h00, 5'h00);
      pg_hold = '0;
      push_ev(8'd1, 16'h0000);
      drive_req(5'h00);
      wait_quiet(1000);
      snap(1'b0, 1'b0, 2'd0, 3'd0, 5'h00, 5'h00);
      push_seq(5'h00, 5'h01);
      drive_req(5'h01);
      wait_quiet(1000);
      snap(1'b0, 1'b0, 2'd0, 3'd0, 5'h01, 5'h01);
      push_seq(5'h01, 5'h00);
      drive_req(5'h00);
      wait_quiet(1000);

      // asynchronous reset while ramping rail 2, then a fresh power-up
      push_ev(8'd1, tup(1'b0, 2'd0, 3'd0, 5'h00, 5'h01));
      push_ev(8'(PG_DLY + 3), tup(1'b0, 2'd0, 3'd0, 5'h01, 5'h01));
      push_ev(8'(STEP + 1), tup(1'b0, 2'd0, 3'd0, 5'h01, 5'h03));
      push_ev(8'(PG_DLY + 3), tup(1'b0, 2'd0, 3'd0, 5'h03, 5'h03));
      push_ev(8'(STEP + 1), tup(1'b0, 2'd0, 3'd0, 5'h03, 5'h07));
      push_ev(ANY, 16'h0000);
      drive_req(5'h1F);
      n = 0;
      while (rail_en != 5'h07 && n < 200) begin
         tick(1);
         n++;
      end
      if (rail_en != 5'h07) fail_wait();
      tick(2);
      #2;
      reset_n = 1'b0;
      snap(1'b0, 1'b0, 2'd0, 3'd0, 5'h00, 5'h00);
      tick(3);
      exp_q.delete();
      push_ev(ANY, 16'h0000);
      exp_q.delete();
      push_seq(5'h00, 5'h1F);
      reset_n  = 1'b1;
      stim_cyc = cyc;
      wait_quiet(1000);
      snap(1'b0, 1'b0, 2'd0, 3'd0, 5'h1F, 5'h1F);

      // randomized request words and dropouts
      on = 5'h1F;
      for (int k = 0; k < 24; k++) begin
         if (on != 5'h00 && $urandom_range(0, 3) == 0) begin
            mask = on & 5'($urandom_range(1, 31));
            if (mask == 5'h00) mask = on & (~on + 5'd1);
            push_ev(8'd3, tup(1'b1, 2'd2, lowest(mask), 5'h00, 5'h00));
            pg_hold  = mask;
            stim_cyc = cyc;
            wait_quiet(1000);
            tick($urandom_range(0, 5));
            snap(1'b0, 1'b1, 2'd2, lowest(mask), 5'h00, 5'h00);
            push_ev(8'd1, 16'h0000);
            drive_req(5'h00);
            wait_quiet(1000);
            pg_hold = '0;
            on = 5'h00;
         end else begin
            nr = 5'($urandom_range(0, 31));
            push_seq(on, nr);
            drive_req(nr);
            wait_quiet(2000);
            snap(1'b0, 1'b0, 2'd0, 3'd0, nr, nr);
            on = nr;
         end
         tick($urandom_range(0, 4));
      end

      push_seq(on, 5'h00);
      drive_req(5'h00);
      wait_quiet(1000);
      snap(1'b0, 1'b0, 2'd0, 3'd0, 5'h00, 5'h00);
      tick(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete, required finish before 500000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/power_rail_sequencer.md
Name: power_rail_sequencer

Overview:
- Consumes the 5-bit rail-request word driven by the VDD1 PIO output stage and turns it into ordered enable pulses for the on-board regulators.
- Enforces power-up order (ascending index) and power-down order (descending index). Monitors regulator power-good, handles timeouts and dropouts, and reports status back to software through a PIO input.

Parameters:
- NUM_RAILS, 5, number of rails; also the width of the request, enable and power-good vectors (max 8).
- STEP_DELAY, 1000, clk cycles of settle time after a rail's power-good before the next step.
- PGOOD_TIMEOUT, 100000, clk cycles allowed from rail enable to synced power-good.
- OFF_DELAY, 1000, clk cycles of discharge wait after disabling a rail.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rail_req  in  NUM_RAILS  requested rail state; bit i=1 requests rail i on. Driven by the PIO out_port.
- pgood_in  in  NUM_RAILS  regulator power-good; asynchronous to clk.
- rail_en  out  NUM_RAILS  regulator enables, registered.
- rail_good  out  NUM_RAILS  rails that are enabled and have passed RAMP (good_mask).
- busy  out  1  high in RAMP, SETTLE or OFF_WAIT.
- fault  out  1  latched fault flag.
- fault_rail  out  3  index of the faulting rail.
- fault_code  out  2  0 none, 1 power-good timeout, 2 power-good dropout.

Behaviour:
- Reset state:
  - rail_en=0, rail_good=0, busy=0, fault=0, fault_rail=0, fault_code=0.
  - State=IDLE, timer=0, pgood synchronisers=0.
- Synchronisation: pgood_in passes through a 2-flop synchroniser to give pg_s. All decisions use pg_s only.
- Timer: 32-bit, cleared on every state entry, increments once per cycle while in RAMP, SETTLE or OFF_WAIT.
- IDLE (evaluated every cycle):
  - Down priority: find the highest i with rail_en[i]=1 and rail_req[i]=0. Next cycle: clear rail_en[i] and good_mask[i], go to OFF_WAIT.
  - Otherwise up: find the lowest i with rail_req[i]=1 and rail_en[i]=0. Next cycle: set rail_en[i], store cur=i, go to RAMP.
  - Otherwise stay in IDLE.
  - Result: rails come up in ascending order and go down in descending order, regardless of the order in which bits change.
- RAMP:
  - If pg_s[cur]=1: set good_mask[cur], go to SETTLE.
  - Else if timer==PGOOD_TIMEOUT-1: go to FAULT with code 1, fault_rail=cur.
  - If both conditions hold in the same cycle, pg_s wins.
- SETTLE: when timer==STEP_DELAY-1, go to IDLE.
- OFF_WAIT: when timer==OFF_DELAY-1, go to IDLE.
- A request change during RAMP, SETTLE or OFF_WAIT never aborts the current step. It is serviced on the next IDLE evaluation.
- Dropout monitor:
  - Active in every state except FAULT.
  - Any i with good_mask[i]=1 and pg_s[i]=0 sends the FSM to FAULT with code 2.
  - fault_rail is the lowest such i.
  - A dropout takes priority over all other transitions in the same cycle.
- FAULT entry (registered, one cycle):
  - rail_en=0 and good_mask=0 for all rails at once; no sequencing.
  - fault=1; fault_code and fault_rail latched.
- FAULT exit:
  - Stay in FAULT while rail_req != 0.
  - The first cycle with rail_req==0 sends the FSM to IDLE and clears fault, fault_code and fault_rail.
- busy is decoded from the state and is registered with it.
- Reset asserted mid-sequence: all outputs return to their reset values immediately, because the reset is asynchronous.

Test Plan (NUM_RAILS=5, STEP_DELAY=4, PGOOD_TIMEOUT=20, OFF_DELAY=3; bench model raises pgood[i] 5 cycles after rail_en[i] rises):
- Power-up ordering:
  - Stimulus: rail_req 0→5'h1F in one cycle.
  - Required: rail_en rises bit0..bit4 in order, one bit per step. Each next enable follows the previous enable by 5 + 2 (sync) + 4 (settle) + ~2 cycles. Final rail_en=rail_good=5'h1F, busy=0.
- Power-down ordering:
  - Stimulus: from 5'h1F, write rail_req=0.
  - Required: rail_en clears bit4..bit0, spaced by OFF_DELAY+1 cycles. Ends at 0 with no fault.
- Timeout:
  - Stimulus: rail_req=5'h03, model holds pgood[1]=0.
  - Required: rail_en[0] stays good. 20 cycles after rail_en[1] rises: fault=1, fault_code=1, fault_rail=1, rail_en=0.
- Dropout:
  - Stimulus: all rails good, then force pgood[2]=0 and pgood[3]=0 in the same cycle.
  - Required: within 3 cycles fault=1, fault_code=2, fault_rail=2, rail_en=0.
- Fault clear:
  - Stimulus: in FAULT, keep rail_req=5'h1F for 10 cycles, then set rail_req=0.
  - Required: fault stays 1 while the request is non-zero. fault clears one cycle after the request reaches 0; re-request 5'h01 then powers up normally.
- Reset mid-ramp:
  - Stimulus: assert reset_n=0 while in RAMP on rail 2.
  - Required: rail_en=0, busy=0 immediately. After release, behaviour matches a fresh power-up.
